branch_predict_gshare: RTL

Parametrised successor to the decode-stage direction predictor. It is selectable at build time between local-history, global-history (gshare) and bimodal indexing. It keeps a speculatively updated global history register (GHR) with mispredict repair and exposes per-branch index and history snapshots for the pipeline to carry to Execute. It also keeps saturating performance counters. It sits in the ID stage: it predicts in D and trains from E.

---
 rtl/branch_predict_gshare_if.sv | 40 ++++
 rtl/branch_predict_gshare.sv | 123 ++++++++++++
 2 files changed

// File: rtl/branch_predict_gshare_if.sv
// Pipeline-side bundle for the decode-stage direction predictor: D-stage lookup
// inputs and outputs, E-stage training inputs, and the performance counters.
interface branch_predict_gshare_if #(
  parameter int PHT_DEPTH = 8,
  parameter int CNT_W     = 32
);
  logic [31:0]          instrD;
  logic                 enaD;
  logic [31:0]          pcD;
  logic [31:0]          pc_plus4D;
  logic [31:0]          pcE;
  logic                 branchE;
  logic                 actual_takeE;
  logic                 pred_takeE;
  logic [PHT_DEPTH-1:0] pht_idxE;
  logic [PHT_DEPTH-1:0] ghrE;

  logic                 branchD;
  logic                 pred_takeD;
  logic [31:0]          branch_targetD;
  logic [PHT_DEPTH-1:0] pht_idxD;
  logic [PHT_DEPTH-1:0] ghrD;
  logic                 mispredE;
  logic [CNT_W-1:0]     br_cnt;
  logic [CNT_W-1:0]     mis_cnt;

  modport master (
    output instrD, enaD, pcD, pc_plus4D, pcE, branchE, actual_takeE,
           pred_takeE, pht_idxE, ghrE,
    input  branchD, pred_takeD, branch_targetD, pht_idxD, ghrD, mispredE,
           br_cnt, mis_cnt
  );

  modport slave (
    input  instrD, enaD, pcD, pc_plus4D, pcE, branchE, actual_takeE,
           pred_takeE, pht_idxE, ghrE,
    output branchD, pred_takeD, branch_targetD, pht_idxD, ghrD, mispredE,
           br_cnt, mis_cnt
  );
endinterface

// File: rtl/branch_predict_gshare.sv
// Decode-stage branch direction predictor: local / gshare / bimodal PHT indexing,
// speculative GHR with mispredict repair, and saturating performance counters.
module branch_predict_gshare #(
  parameter int         PHT_DEPTH = 8,
  parameter int         BHT_DEPTH = 4,
  parameter int         MODE      = 1,
  parameter logic [1:0] PHT_INIT  = 2'b01,
  parameter int         CNT_W     = 32
) (
  input logic                clk,
  input logic                rst,
  branch_predict_gshare_if.slave bp
);
  localparam int PHT_N = 1 << PHT_DEPTH;
  localparam int BHT_N = 1 << BHT_DEPTH;

  logic [1:0]           pht_q [PHT_N];
  logic [1:0]           pht_d [PHT_N];
  logic [PHT_DEPTH-1:0] bht_q [BHT_N];
  logic [PHT_DEPTH-1:0] bht_d [BHT_N];
  logic [PHT_DEPTH-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0]     br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]     mis_cnt_q, mis_cnt_d;

  logic [5:0]           opcode;
  logic                 branch_dec;
  logic [BHT_DEPTH-1:0] bht_rd_idx, bht_wr_idx;
  logic [PHT_DEPTH-1:0] pc_idx, local_hist, ghr_view, pht_idx;
  logic [1:0]           ctr_rd;
  logic                 pred_take;
  logic                 mispred;
  logic                 unused_bits;

  // Counter encoding 00 SNT, 01 WNT, 11 WT, 10 ST; prediction is bit[1].
  function automatic logic [1:0] ctr_train(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    case (c)
      2'b00:   n = taken ? 2'b01 : 2'b00;
      2'b01:   n = taken ? 2'b11 : 2'b00;
      2'b11:   n = taken ? 2'b10 : 2'b01;
      default: n = taken ? 2'b10 : 2'b11;
    endcase
    return n;
  endfunction

  assign opcode     = bp.instrD[31:26];
  assign branch_dec = ((opcode == 6'b000001) && (bp.instrD[20:18] == 3'b000)) ||
                      (opcode[5:2] == 4'b0001);

  assign bht_rd_idx = bp.pcD[BHT_DEPTH+1:2];
  assign bht_wr_idx = bp.pcE[BHT_DEPTH+1:2];
  assign pc_idx     = bp.pcD[PHT_DEPTH+1:2];

  // While rst is held the lookup path sees the reset state, not the old tables.
  assign local_hist = rst ? '0 : bht_q[bht_rd_idx];
  assign ghr_view   = rst ? '0 : ghr_q;

  always_comb begin
    case (MODE)
      0:       pht_idx = local_hist;
      1:       pht_idx = ghr_view ^ pc_idx;
      default: pht_idx = pc_idx;
    endcase
  end

  assign ctr_rd    = rst ? PHT_INIT : pht_q[pht_idx];
  assign pred_take = bp.enaD & branch_dec & ctr_rd[1];
  assign mispred   = bp.branchE & (bp.actual_takeE != bp.pred_takeE);

  always_comb begin
    pht_d     = pht_q;
    bht_d     = bht_q;
    ghr_d     = ghr_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;

    if (bp.branchE) begin
      pht_d[bp.pht_idxE] = ctr_train(pht_q[bp.pht_idxE], bp.actual_takeE);
      if (MODE == 0)
        bht_d[bht_wr_idx] = {bht_q[bht_wr_idx][PHT_DEPTH-2:0], bp.actual_takeE};
      if (br_cnt_q != '1)
        br_cnt_d = br_cnt_q + CNT_W'(1);
    end

    if (mispred && (mis_cnt_q != '1))
      mis_cnt_d = mis_cnt_q + CNT_W'(1);

    // Repair wins; the D-stage branch in that cycle is being flushed anyway.
    if (MODE == 1) begin
      if (mispred)
        ghr_d = {bp.ghrE[PHT_DEPTH-2:0], bp.actual_takeE};
      else if (bp.enaD && branch_dec)
        ghr_d = {ghr_q[PHT_DEPTH-2:0], pred_take};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= PHT_INIT;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= '0;
      ghr_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      pht_q     <= pht_d;
      bht_q     <= bht_d;
      ghr_q     <= ghr_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign bp.branchD        = branch_dec;
  assign bp.pred_takeD     = pred_take;
  assign bp.branch_targetD = bp.pc_plus4D + {{14{bp.instrD[15]}}, bp.instrD[15:0], 2'b00};
  assign bp.pht_idxD       = pht_idx;
  assign bp.ghrD           = ghr_view;
  assign bp.mispredE       = mispred;
  assign bp.br_cnt         = rst ? '0 : br_cnt_q;
  assign bp.mis_cnt        = rst ? '0 : mis_cnt_q;

  assign unused_bits = ^{bp.instrD[25:21], bp.instrD[17:16], bp.pcD, bp.pcE, bp.ghrE};
endmodule
